// File: rtl/and_seq_pkg.sv
// ============================================================================
// Module : and_seq_pkg
// Brief  : Shared types and helpers for the AND-path sequencer.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package and_seq_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    EVAL  = 3'd2,
    HOLD  = 3'd3,
    RESP  = 3'd4
  } state_t;

  // Enough bits to hold the largest phase length without wrapping.
  function automatic int cnt_width(input int s, input int p, input int h);
    int m;
    m = s;
    if (p > m) m = p;
    if (h > m) m = h;
    return $clog2(m + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/and_path_sequencer_if.sv
// ============================================================================
// Module : and_path_sequencer_if
// Brief  : Request, datapath and response bundle of the AND-path sequencer.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface and_path_sequencer_if
  import and_seq_pkg::*;
#(
  parameter int WIDTH = 8
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [WIDTH-1:0]         dp_a;
  logic [WIDTH-1:0]         dp_b;
  logic [WIDTH-1:0]         dp_out;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic                     rsp_id;
  logic [WIDTH-1:0]         rsp_data;
  logic                     rsp_viol;

  modport master (
    output req_valid, req_a, req_b, dp_out, rsp_ready,
    input  req_ready, dp_a, dp_b, rsp_valid, rsp_id, rsp_data, rsp_viol
  );

  modport slave (
    input  req_valid, req_a, req_b, dp_out, rsp_ready,
    output req_ready, dp_a, dp_b, rsp_valid, rsp_id, rsp_data, rsp_viol
  );
endinterface

`default_nettype wire

// File: rtl/and_seq_rr_arb.sv
// ============================================================================
// Module : and_seq_rr_arb
// Brief  : Two-way round-robin arbiter; requester 0 has priority after reset.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module and_seq_rr_arb
  import and_seq_pkg::*;
(
  input  wire logic               clk,
  input  wire logic               rst_n,
  input  wire logic [NUM_REQ-1:0] valid,
  input  wire logic               advance,
  output logic      [NUM_REQ-1:0] grant,
  output logic                    idx
);

  logic last;

  always_comb begin
    idx   = 1'b0;
    grant = '0;
    if (valid[0] && valid[1]) begin
      idx = ~last;
    end else if (valid[1]) begin
      idx = 1'b1;
    end
    if (|valid) begin
      grant = idx ? 2'b10 : 2'b01;
    end
  end

  // Pointer moves only when a grant is actually taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= 1'b1;
    end else if (advance && |valid) begin
      last <= idx;
    end
  end

endmodule

`default_nettype wire

// File: rtl/and_path_sequencer.sv
// ============================================================================
// Module : and_path_sequencer
// Brief  : Arbitrates operand pairs onto an AND datapath with setup/path/hold
//          windows counted in cycles. TIMING_CHECK_EN adds a hold checker.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module and_path_sequencer
  import and_seq_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int SETUP_CYC = 5,
  parameter int PATH_CYC  = 10,
  parameter int HOLD_CYC  = 5
)(
  input  wire logic       clk,
  input  wire logic       rst_n,
  and_path_sequencer_if.slave bus
);

  localparam int CW = cnt_width(SETUP_CYC, PATH_CYC, HOLD_CYC);

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            accept, capture;
  logic [1:0]      grant;
  logic            gidx;

  and_seq_rr_arb u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid   (bus.req_valid),
    .advance (state == IDLE),
    .grant   (grant),
    .idx     (gidx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (|bus.req_valid) begin
          accept    = 1'b1;
          state_nxt = SETUP;
          cnt_nxt   = CW'(SETUP_CYC - 1);
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          state_nxt = EVAL;
          cnt_nxt   = CW'(PATH_CYC - 1);
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      EVAL: begin
        if (cnt == '0) begin
          capture   = 1'b1;
          state_nxt = HOLD;
          cnt_nxt   = CW'(HOLD_CYC - 1);
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Operands load only on accept so the datapath never sees a mid-transaction change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.dp_a     <= '0;
      bus.dp_b     <= '0;
      bus.rsp_id   <= 1'b0;
      bus.rsp_data <= '0;
    end else begin
      if (accept) begin
        bus.dp_a   <= gidx ? bus.req_a[2*WIDTH-1:WIDTH] : bus.req_a[WIDTH-1:0];
        bus.dp_b   <= gidx ? bus.req_b[2*WIDTH-1:WIDTH] : bus.req_b[WIDTH-1:0];
        bus.rsp_id <= gidx;
      end
      if (capture) begin
        bus.rsp_data <= bus.dp_out;
      end
    end
  end

`ifdef TIMING_CHECK_EN
  logic viol;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      viol <= 1'b0;
    end else if (accept) begin
      viol <= 1'b0;
    end else if (state == HOLD && bus.dp_out != bus.rsp_data) begin
      viol <= 1'b1;
    end
  end

  assign bus.rsp_viol = viol;
`else
  assign bus.rsp_viol = 1'b0;
`endif

  // Gated by rst_n so the strobe is quiet while reset is held.
  assign bus.req_ready = (state == IDLE && rst_n) ? grant : '0;
  assign bus.rsp_valid = (state == RESP);

endmodule

`default_nettype wire

// File: tb/tb_and_path_sequencer.sv
// ============================================================================
// Module : tb_and_path_sequencer
// Brief  : Randomised self-checking bench with a transaction-level model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_and_path_sequencer;

  localparam int W   = 8;
  localparam int S   = 5;
  localparam int P   = 10;
  localparam int H   = 5;
  localparam int LAT = S + P + H + 1;
  localparam int LATF = 4;
`ifdef TIMING_CHECK_EN
  localparam bit TIMING_EN = 1'b1;
`else
  localparam bit TIMING_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  and_path_sequencer_if #(.WIDTH(W)) bus ();
  and_path_sequencer_if #(.WIDTH(W)) fbus ();

  logic         force_en = 1'b0;
  logic [W-1:0] force_val = '0;
  assign bus.dp_out  = force_en ? force_val : (bus.dp_a & bus.dp_b);
  assign fbus.dp_out = fbus.dp_a & fbus.dp_b;

  and_path_sequencer #(.WIDTH(W), .SETUP_CYC(S), .PATH_CYC(P), .HOLD_CYC(H)) dut (
    .clk (clk), .rst_n (rst_n), .bus (bus.slave)
  );

  and_path_sequencer #(.WIDTH(W), .SETUP_CYC(1), .PATH_CYC(1), .HOLD_CYC(1)) dut_fast (
    .clk (clk), .rst_n (rst_n), .bus (fbus.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit last_g = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Round-robin rule: with both asking, the one not served last wins.
  function automatic bit pick(input logic [1:0] v, input bit last);
    if (v == 2'b11) return ~last;
    return v[1];
  endfunction

  // Called at a negedge; returns one negedge (+1) after the response handshake.
  task automatic run_txn(input logic [1:0] v, input logic [W-1:0] a0, b0, a1, b1,
                         input int bp, input bit perturb);
    bit g;
    logic [W-1:0] ea, eb, ed;
    bit ev;
    bus.req_valid = v;
    bus.req_a     = {a1, a0};
    bus.req_b     = {b1, b0};
    bus.rsp_ready = 1'b0;
    #1;
    g      = pick(v, last_g);
    last_g = g;
    ea     = g ? a1 : a0;
    eb     = g ? b1 : b0;
    ed     = ea & eb;
    ev     = perturb && TIMING_EN;
    check("grant", 32'(bus.req_ready), 32'(2'b01 << g));
    for (int k = 1; k <= LAT + bp; k++) begin
      @(negedge clk);
      bus.req_valid = 2'($urandom_range(0, 3));
      bus.req_a     = 16'($urandom);
      bus.req_b     = 16'($urandom);
      bus.rsp_ready = (k < LAT) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (perturb && k == S + P + 2) begin
        force_en  = 1'b1;
        force_val = ed ^ 8'h01;
      end
      if (k == S + P + 3) force_en = 1'b0;
      if (k == LAT + bp) begin
        bus.req_valid = 2'b00;
        bus.rsp_ready = 1'b1;
      end
      #1;
      check("dp_a_stable", 32'(bus.dp_a), 32'(ea));
      check("dp_b_stable", 32'(bus.dp_b), 32'(eb));
      check("ready_busy", 32'(bus.req_ready), 32'(0));
      check("rsp_valid", 32'(bus.rsp_valid), 32'(k >= LAT));
      if (k >= LAT) begin
        check("rsp_id", 32'(bus.rsp_id), 32'(g));
        check("rsp_data", 32'(bus.rsp_data), 32'(ed));
        check("rsp_viol", 32'(bus.rsp_viol), 32'(ev));
      end
    end
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    #1;
    check("idle_after_rsp", 32'(bus.rsp_valid), 32'(0));
  endtask

  task automatic idle_cycles(input int n);
    bus.req_valid = 2'b00;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      check("idle_ready", 32'(bus.req_ready), 32'(0));
      check("idle_valid", 32'(bus.rsp_valid), 32'(0));
    end
  endtask

  initial begin
    logic [1:0] fv;
    logic [W-1:0] fa, fb;
    bit fg;

    // Reset with requests pending: everything must stay quiet.
    bus.req_valid  = 2'b11;
    bus.req_a      = 16'hA5A5;
    bus.req_b      = 16'h5A5A;
    bus.rsp_ready  = 1'b0;
    fbus.req_valid = 2'b00;
    fbus.req_a     = '0;
    fbus.req_b     = '0;
    fbus.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_ready", 32'(bus.req_ready), 32'(0));
    check("rst_dp_a", 32'(bus.dp_a), 32'(0));
    check("rst_dp_b", 32'(bus.dp_b), 32'(0));
    check("rst_valid", 32'(bus.rsp_valid), 32'(0));
    check("rst_id", 32'(bus.rsp_id), 32'(0));
    check("rst_data", 32'(bus.rsp_data), 32'(0));
    check("rst_viol", 32'(bus.rsp_viol), 32'(0));
    bus.req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(2);

    // Contention straight after reset: 0,1,0,1.
    for (int i = 0; i < 4; i++)
      run_txn(2'b11, W'($urandom), W'($urandom), W'($urandom), W'($urandom), 0, 1'b0);

    // Single requester, reference operands.
    run_txn(2'b01, 8'hF0, 8'h3C, 8'h00, 8'h00, 0, 1'b0);
    // Backpressure.
    run_txn(2'b10, 8'h00, 8'h00, 8'hF0, 8'h3C, 7, 1'b0);
    // Hold-window disturbance, then a clean rerun.
    run_txn(2'b01, 8'hF0, 8'h3C, 8'h00, 8'h00, 1, 1'b1);
    run_txn(2'b01, 8'hF0, 8'h3C, 8'h00, 8'h00, 0, 1'b0);

    // Randomised traffic.
    for (int i = 0; i < 10; i++) begin
      if ($urandom_range(0, 2) == 0) idle_cycles(int'($urandom_range(1, 3)));
      run_txn(2'($urandom_range(1, 3)), W'($urandom), W'($urandom), W'($urandom),
              W'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of EVAL.
    bus.req_valid = 2'b11;
    bus.req_a     = 16'h1234;
    bus.req_b     = 16'hFFFF;
    #1;
    fg     = pick(2'b11, last_g);
    check("abort_grant", 32'(bus.req_ready), 32'(2'b01 << fg));
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      bus.req_valid = 2'b11;
    end
    rst_n = 1'b0;
    #1;
    check("abort_dp_a", 32'(bus.dp_a), 32'(0));
    check("abort_dp_b", 32'(bus.dp_b), 32'(0));
    check("abort_data", 32'(bus.rsp_data), 32'(0));
    check("abort_valid", 32'(bus.rsp_valid), 32'(0));
    check("abort_ready", 32'(bus.req_ready), 32'(0));
    last_g = 1'b1;
    @(negedge clk);
    bus.req_valid = 2'b00;
    rst_n = 1'b1;
    idle_cycles(1);
    run_txn(2'b11, 8'h0F, 8'hFF, 8'hF0, 8'hFF, 0, 1'b0);

    // Minimal windows on the second instance.
    for (int i = 0; i < 4; i++) begin
      fv = (i % 2 == 1) ? 2'b10 : 2'b01;
      fa = W'($urandom);
      fb = W'($urandom);
      fbus.req_valid = fv;
      fbus.req_a     = {fa, fa ^ 8'hFF};
      fbus.req_b     = {fb, fb ^ 8'h55};
      #1;
      check("f_grant", 32'(fbus.req_ready), 32'(fv));
      if (fv == 2'b01) begin
        fa = fa ^ 8'hFF;
        fb = fb ^ 8'h55;
      end
      for (int k = 1; k <= LATF; k++) begin
        @(negedge clk);
        fbus.req_valid = 2'b00;
        fbus.req_a     = 16'($urandom);
        fbus.req_b     = 16'($urandom);
        fbus.rsp_ready = (k == LATF);
        #1;
        check("f_dp_a", 32'(fbus.dp_a), 32'(fa));
        check("f_dp_b", 32'(fbus.dp_b), 32'(fb));
        check("f_rsp_valid", 32'(fbus.rsp_valid), 32'(k == LATF));
        if (k == LATF) begin
          check("f_rsp_data", 32'(fbus.rsp_data), 32'(fa & fb));
          check("f_rsp_id", 32'(fbus.rsp_id), 32'(fv[1]));
        end
      end
      @(negedge clk);
      fbus.rsp_ready = 1'b0;
      #1;
      check("f_idle", 32'(fbus.rsp_valid), 32'(0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
